// File: rtl/labeler_pkg.sv
// Shared types and defaults for the label equivalence table.
//   LABEL_WIDTH      - default label width; label 0 is background
//   MERGE_FIFO_DEPTH - default merge queue depth (power of 2)
//   label_t          - one label at the default width
//   merge_pair_t     - an equivalent label pair {a, b}
//   equiv_state_t    - resolver FSM states
package labeler_pkg;

    localparam int unsigned LABEL_WIDTH      = 8;
    localparam int unsigned MERGE_FIFO_DEPTH = 16;

    typedef logic [LABEL_WIDTH-1:0] label_t;

    typedef struct packed {
        label_t a;
        label_t b;
    } merge_pair_t;

    typedef enum logic [2:0] {
        StIdle,
        StFindA,
        StFindB,
        StLink,
        StFlatten,
        StDone
    } equiv_state_t;

endpackage

// File: rtl/label_equiv_table_if.sv
// Labeler-side bus of the label equivalence table.
//   master: labeler/host side (drives frame control, labels, merges, lookups)
//   slave : table side (returns lookups, busy, done, overflow)
interface label_equiv_table_if #(
    parameter int unsigned LABEL_WIDTH = labeler_pkg::LABEL_WIDTH
);
    logic                   frame_start;
    logic                   new_label_valid;
    logic [LABEL_WIDTH-1:0] new_label_value;
    logic                   merge_labels;
    logic [LABEL_WIDTH-1:0] merge_a;
    logic [LABEL_WIDTH-1:0] merge_b;
    logic                   frame_end;
    logic                   resolve_req;
    logic [LABEL_WIDTH-1:0] resolve_label;
    logic                   resolve_valid;
    logic [LABEL_WIDTH-1:0] resolved_label;
    logic                   busy;
    logic                   done;
    logic                   overflow;

    modport master (
        output frame_start, new_label_valid, new_label_value, merge_labels, merge_a, merge_b,
               frame_end, resolve_req, resolve_label,
        input  resolve_valid, resolved_label, busy, done, overflow
    );

    modport slave (
        input  frame_start, new_label_valid, new_label_value, merge_labels, merge_a, merge_b,
               frame_end, resolve_req, resolve_label,
        output resolve_valid, resolved_label, busy, done, overflow
    );

endinterface

// File: rtl/label_merge_fifo.sv
// Synchronous FIFO holding queued merge pairs.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_flush        : empties the queue (wins over push/pop)
//   i_push, i_data : enqueue; ignored when full
//   i_pop, o_data  : dequeue; o_data shows the head entry
//   o_full, o_empty: occupancy flags
module label_merge_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AddrW:0]   r_wptr;
    logic [AddrW:0]   r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                       (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_data    = r_mem[r_rptr[AddrW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (i_flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AddrW-1:0]] <= i_data;
    end

endmodule

// File: rtl/label_equiv_table.sv
// Union-find equivalence table for a connected-component labeler.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : frame control, label allocation, merge reports, lookups,
//                    and busy/done/overflow status
// Merges are queued, resolved one at a time (find a, find b, link higher root to
// lower), then the table is flattened so every entry points straight at its root.
module label_equiv_table #(
    parameter int unsigned LABEL_WIDTH      = labeler_pkg::LABEL_WIDTH,
    parameter int unsigned MERGE_FIFO_DEPTH = labeler_pkg::MERGE_FIFO_DEPTH
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    label_equiv_table_if.slave  bus
);
    import labeler_pkg::*;

    localparam int unsigned NumLabels = 1 << LABEL_WIDTH;

    typedef logic [LABEL_WIDTH-1:0] lbl_t;

    // Parent table: no reset; entries are initialised by label allocation.
    lbl_t         r_parent [NumLabels];

    equiv_state_t r_state, w_state_next;
    lbl_t         r_x, w_x_next;
    lbl_t         r_b, w_b_next;
    lbl_t         r_ra, w_ra_next;
    lbl_t         r_rb, w_rb_next;
    lbl_t         r_i, w_i_next;
    lbl_t         r_max_label;
    logic         r_end_pending;
    logic         r_overflow;
    logic         r_resolve_valid;
    lbl_t         r_resolved_label;

    logic         w_new_wr;
    logic         w_merge_ok;
    logic         w_fifo_full;
    logic         w_fifo_empty;
    logic         w_pop;
    logic [2*LABEL_WIDTH-1:0] w_pop_data;
    logic         w_fsm_we;
    lbl_t         w_fsm_addr;
    lbl_t         w_fsm_data;
    logic         w_we;
    lbl_t         w_waddr;
    lbl_t         w_wdata;
    lbl_t         w_px;
    lbl_t         w_ppi;
    lbl_t         w_link_hi;
    lbl_t         w_link_lo;

    // frame_start discards any same-cycle allocation or merge.
    assign w_new_wr   = bus.new_label_valid && (bus.new_label_value != '0) && !bus.frame_start;
    assign w_merge_ok = bus.merge_labels && !bus.frame_start && (bus.merge_a != '0) &&
                        (bus.merge_b != '0) && (bus.merge_a != bus.merge_b);

    label_merge_fifo #(
        .WIDTH (2 * LABEL_WIDTH),
        .DEPTH (MERGE_FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (bus.frame_start),
        .i_push  (w_merge_ok),
        .i_data  ({bus.merge_a, bus.merge_b}),
        .i_pop   (w_pop),
        .o_data  (w_pop_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign w_px      = r_parent[r_x];
    assign w_ppi     = r_parent[r_parent[r_i]];
    assign w_link_hi = (r_ra > r_rb) ? r_ra : r_rb;
    assign w_link_lo = (r_ra > r_rb) ? r_rb : r_ra;

    always_comb begin
        w_state_next = r_state;
        w_x_next     = r_x;
        w_b_next     = r_b;
        w_ra_next    = r_ra;
        w_rb_next    = r_rb;
        w_i_next     = r_i;
        w_pop        = 1'b0;
        w_fsm_we     = 1'b0;
        w_fsm_addr   = '0;
        w_fsm_data   = '0;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_x_next     = w_pop_data[2*LABEL_WIDTH-1:LABEL_WIDTH];
                    w_b_next     = w_pop_data[LABEL_WIDTH-1:0];
                    w_state_next = StFindA;
                end else if (r_end_pending) begin
                    if (r_max_label == '0) begin
                        w_state_next = StDone;
                    end else begin
                        w_i_next     = lbl_t'(1);
                        w_state_next = StFlatten;
                    end
                end
            end
            StFindA: begin
                if (w_px == r_x) begin
                    w_ra_next    = r_x;
                    w_x_next     = r_b;
                    w_state_next = StFindB;
                end else begin
                    w_x_next = w_px;
                end
            end
            StFindB: begin
                if (w_px == r_x) begin
                    w_rb_next    = r_x;
                    w_state_next = StLink;
                end else begin
                    w_x_next = w_px;
                end
            end
            StLink: begin
                if (r_ra == r_rb) begin
                    w_state_next = StIdle;
                end else if (!w_new_wr) begin
                    // Allocation owns the write port; otherwise retry next cycle.
                    w_fsm_we     = 1'b1;
                    w_fsm_addr   = w_link_hi;
                    w_fsm_data   = w_link_lo;
                    w_state_next = StIdle;
                end
            end
            StFlatten: begin
                // Lower entries are already flat, so one hop reaches the root.
                if (!w_new_wr) begin
                    w_fsm_we   = 1'b1;
                    w_fsm_addr = r_i;
                    w_fsm_data = w_ppi;
                    if (r_i == r_max_label) begin
                        w_state_next = StDone;
                    end else begin
                        w_i_next = r_i + lbl_t'(1);
                    end
                end
            end
            StDone: begin
                // Late merges reopen resolution; end_pending re-flattens afterwards.
                if (!w_fifo_empty) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
        if (bus.frame_start) begin
            w_state_next = StIdle;
            w_pop        = 1'b0;
            w_fsm_we     = 1'b0;
        end
    end

    assign w_we    = w_new_wr || w_fsm_we;
    assign w_waddr = w_new_wr ? bus.new_label_value : w_fsm_addr;
    assign w_wdata = w_new_wr ? bus.new_label_value : w_fsm_data;

    always_ff @(posedge i_clk) begin
        if (w_we) r_parent[w_waddr] <= w_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= StIdle;
            r_x              <= '0;
            r_b              <= '0;
            r_ra             <= '0;
            r_rb             <= '0;
            r_i              <= '0;
            r_max_label      <= '0;
            r_end_pending    <= 1'b0;
            r_overflow       <= 1'b0;
            r_resolve_valid  <= 1'b0;
            r_resolved_label <= '0;
        end else begin
            r_state <= w_state_next;
            r_x     <= w_x_next;
            r_b     <= w_b_next;
            r_ra    <= w_ra_next;
            r_rb    <= w_rb_next;
            r_i     <= w_i_next;
            if (bus.frame_start) begin
                r_max_label   <= '0;
                r_end_pending <= 1'b0;
                r_overflow    <= 1'b0;
            end else begin
                if (w_new_wr && (bus.new_label_value > r_max_label)) begin
                    r_max_label <= bus.new_label_value;
                end
                if (bus.frame_end)              r_end_pending <= 1'b1;
                if (w_merge_ok && w_fifo_full)  r_overflow    <= 1'b1;
            end
            r_resolve_valid <= (r_state == StDone) && bus.resolve_req;
            if ((r_state == StDone) && bus.resolve_req) begin
                r_resolved_label <= (bus.resolve_label == '0) ? '0 : r_parent[bus.resolve_label];
            end
        end
    end

    assign bus.resolve_valid  = r_resolve_valid;
    assign bus.resolved_label = r_resolved_label;
    assign bus.done           = (r_state == StDone);
    assign bus.busy           = !w_fifo_empty || !((r_state == StIdle) || (r_state == StDone));
    assign bus.overflow       = r_overflow;

endmodule
